// File: rtl/warp_fetcher_if.sv
// warp_fetcher_if: scheduler request, program-memory read and instruction result signals of warp_fetcher.
interface warp_fetcher_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
);
    logic                 fetch_req;
    logic [7:0]           warp_id;
    logic [ADDR_BITS-1:0] pc;
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 instruction_ready;
    logic [DATA_BITS-1:0] instruction;
    logic [7:0]           fetch_warp_id;
    modport master (
        output fetch_req, warp_id, pc, mem_read_ready, mem_read_data,
        input  mem_read_valid, mem_read_address, instruction_ready, instruction, fetch_warp_id
    );
    modport slave (
        input  fetch_req, warp_id, pc, mem_read_ready, mem_read_data,
        output mem_read_valid, mem_read_address, instruction_ready, instruction, fetch_warp_id
    );
endinterface

// File: rtl/warp_fetcher.sv
// warp_fetcher: per-warp instruction fetch FSM (IDLE/FETCHING/FETCHED) in front of program memory.
// Define FETCH_CACHE_EN to add a one-entry-per-warp instruction cache that short-circuits repeat fetches.
module warp_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int MAX_WARPS_PER_CORE    = 4
) (
    input logic           clk,
    input logic           reset,
    warp_fetcher_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCHING, FETCHED} state_t;
    state_t                           state;
    logic [7:0]                       cur_warp;
    logic                             aborted;
    logic                             hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] hit_data;
`ifdef FETCH_CACHE_EN
    localparam int IW = MAX_WARPS_PER_CORE > 1 ? $clog2(MAX_WARPS_PER_CORE) : 1;
    localparam logic [8:0] NW = 9'(MAX_WARPS_PER_CORE);
    logic [MAX_WARPS_PER_CORE-1:0]    c_valid;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] c_tag  [MAX_WARPS_PER_CORE];
    logic [PROGRAM_MEM_DATA_BITS-1:0] c_data [MAX_WARPS_PER_CORE];
    logic                             req_in, cur_in;
    logic [IW-1:0]                    req_idx, cur_idx;
    assign req_in   = {1'b0, bus.warp_id} < NW;
    assign cur_in   = {1'b0, cur_warp} < NW;
    assign req_idx  = IW'(bus.warp_id);
    assign cur_idx  = IW'(cur_warp);
    assign hit      = req_in && c_valid[req_idx] && c_tag[req_idx] == bus.pc;
    assign hit_data = req_in ? c_data[req_idx] : '0;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif
    // mem_read_address doubles as the latched pc of the current request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            bus.mem_read_valid    <= 1'b0;
            bus.mem_read_address  <= '0;
            bus.instruction_ready <= 1'b0;
            bus.instruction       <= '0;
            bus.fetch_warp_id     <= '0;
            cur_warp              <= '0;
            aborted               <= 1'b0;
`ifdef FETCH_CACHE_EN
            c_valid               <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.fetch_req) begin
                    cur_warp             <= bus.warp_id;
                    bus.mem_read_address <= bus.pc;
                    aborted              <= 1'b0;
                    if (hit) begin
                        state                 <= FETCHED;
                        bus.instruction_ready <= 1'b1;
                        bus.instruction       <= hit_data;
                        bus.fetch_warp_id     <= bus.warp_id;
                    end else begin
                        state              <= FETCHING;
                        bus.mem_read_valid <= 1'b1;
                    end
                end
                FETCHING: begin
                    if (!bus.fetch_req) aborted <= 1'b1;
                    if (bus.mem_read_ready) begin
                        bus.mem_read_valid <= 1'b0;
`ifdef FETCH_CACHE_EN
                        if (cur_in) begin
                            c_valid[cur_idx] <= 1'b1;
                            c_tag[cur_idx]   <= bus.mem_read_address;
                            c_data[cur_idx]  <= bus.mem_read_data;
                        end
`endif
                        // A request withdrawn at any point of the transaction loses its data.
                        if (bus.fetch_req && !aborted) begin
                            state                 <= FETCHED;
                            bus.instruction_ready <= 1'b1;
                            bus.instruction       <= bus.mem_read_data;
                            bus.fetch_warp_id     <= cur_warp;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FETCHED: if (!bus.fetch_req) begin
                    state                 <= IDLE;
                    bus.instruction_ready <= 1'b0;
                end else if (bus.warp_id != cur_warp || bus.pc != bus.mem_read_address) begin
                    state                 <= FETCHING;
                    bus.instruction_ready <= 1'b0;
                    bus.mem_read_valid    <= 1'b1;
                    bus.mem_read_address  <= bus.pc;
                    cur_warp              <= bus.warp_id;
                    aborted               <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_warp_fetcher.sv
// tb_warp_fetcher: directed checks of warp_fetcher handshake timing, abort, reset and (with FETCH_CACHE_EN) cache hits.
module tb_warp_fetcher;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    warp_fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) bus ();
    warp_fetcher dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic r, input logic [7:0] w, input logic [7:0] p, input logic rdy, input logic [15:0] d);
        bus.fetch_req      = r;
        bus.warp_id        = w;
        bus.pc             = p;
        bus.mem_read_ready = rdy;
        bus.mem_read_data  = d;
    endtask
    task automatic outs(input string tag, input logic v, input logic [7:0] a, input logic ir);
        check({tag, ".valid"}, 32'(bus.mem_read_valid), 32'(v));
        check({tag, ".addr"}, 32'(bus.mem_read_address), 32'(a));
        check({tag, ".ir"}, 32'(bus.instruction_ready), 32'(ir));
    endtask
    task automatic result(input string tag, input logic [15:0] ins, input logic [7:0] w);
        check({tag, ".instr"}, 32'(bus.instruction), 32'(ins));
        check({tag, ".fwid"}, 32'(bus.fetch_warp_id), 32'(w));
    endtask
    initial begin
        drive(1'b0, 8'h00, 8'h00, 1'b0, 16'h0000);
        tick;
        tick;
        outs("reset", 1'b0, 8'h00, 1'b0);
        result("reset", 16'h0000, 8'h00);
        reset = 1'b0;
        // immediate ready: valid one cycle, result two edges after the request
        drive(1'b1, 8'h00, 8'h00, 1'b1, 16'hA5A5);
        tick;
        outs("t1.n", 1'b1, 8'h00, 1'b0);
        tick;
        outs("t1.n1", 1'b0, 8'h00, 1'b1);
        result("t1.n1", 16'hA5A5, 8'h00);
        tick;
        outs("t1.hold", 1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 16'h0000);
        tick;
        outs("t1.drop", 1'b0, 8'h00, 1'b0);
        // ready delayed three cycles; warp_id/pc wiggle while fetching is ignored
        drive(1'b1, 8'h00, 8'h10, 1'b0, 16'h1234);
        tick;
        outs("t2.c1", 1'b1, 8'h10, 1'b0);
        drive(1'b1, 8'h09, 8'h77, 1'b0, 16'h1234);
        tick;
        outs("t2.c2", 1'b1, 8'h10, 1'b0);
        tick;
        outs("t2.c3", 1'b1, 8'h10, 1'b0);
        drive(1'b1, 8'h00, 8'h10, 1'b1, 16'h1234);
        tick;
        outs("t2.done", 1'b0, 8'h10, 1'b1);
        result("t2.done", 16'h1234, 8'h00);
        drive(1'b0, 8'h00, 8'h10, 1'b0, 16'h0000);
        tick;
        outs("t2.drop", 1'b0, 8'h10, 1'b0);
        // new warp/pc while FETCHED restarts the fetch
        drive(1'b1, 8'h00, 8'h20, 1'b1, 16'h1111);
        tick;
        tick;
        outs("t3.first", 1'b0, 8'h20, 1'b1);
        result("t3.first", 16'h1111, 8'h00);
        drive(1'b1, 8'h01, 8'h04, 1'b0, 16'h2222);
        tick;
        outs("t3.restart", 1'b1, 8'h04, 1'b0);
        drive(1'b1, 8'h01, 8'h04, 1'b1, 16'h2222);
        tick;
        outs("t3.done", 1'b0, 8'h04, 1'b1);
        result("t3.done", 16'h2222, 8'h01);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 16'h0000);
        tick;
        outs("t3.drop", 1'b0, 8'h04, 1'b0);
        // request withdrawn mid-fetch: transaction completes, data discarded
        drive(1'b1, 8'h03, 8'h30, 1'b0, 16'h3333);
        tick;
        outs("t4.c1", 1'b1, 8'h30, 1'b0);
        drive(1'b0, 8'h03, 8'h30, 1'b0, 16'h3333);
        tick;
        outs("t4.c2", 1'b1, 8'h30, 1'b0);
        drive(1'b0, 8'h03, 8'h30, 1'b1, 16'h3333);
        tick;
        outs("t4.done", 1'b0, 8'h30, 1'b0);
        result("t4.done", 16'h2222, 8'h01);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 16'h0000);
        tick;
        outs("t4.idle", 1'b0, 8'h30, 1'b0);
        // reset while fetching, then a late ready
        drive(1'b1, 8'h05, 8'h40, 1'b0, 16'h5555);
        tick;
        outs("t5.c1", 1'b1, 8'h40, 1'b0);
        reset = 1'b1;
        tick;
        outs("t5.rst", 1'b0, 8'h00, 1'b0);
        result("t5.rst", 16'h0000, 8'h00);
        reset = 1'b0;
        drive(1'b0, 8'h05, 8'h40, 1'b1, 16'h5555);
        tick;
        outs("t5.late", 1'b0, 8'h00, 1'b0);
        result("t5.late", 16'h0000, 8'h00);
        // all-ones pc fetched normally
        drive(1'b1, 8'h07, 8'hFF, 1'b1, 16'hBEEF);
        tick;
        outs("t6.req", 1'b1, 8'hFF, 1'b0);
        tick;
        outs("t6.done", 1'b0, 8'hFF, 1'b1);
        result("t6.done", 16'hBEEF, 8'h07);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 16'h0000);
        tick;
`ifdef FETCH_CACHE_EN
        drive(1'b1, 8'h02, 8'h08, 1'b1, 16'hC0DE);
        tick;
        tick;
        outs("c.fill", 1'b0, 8'h08, 1'b1);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 16'h0000);
        tick;
        drive(1'b1, 8'h02, 8'h08, 1'b0, 16'h0000);
        tick;
        outs("c.hit", 1'b0, 8'h08, 1'b1);
        result("c.hit", 16'hC0DE, 8'h02);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 16'h0000);
        tick;
        drive(1'b1, 8'h02, 8'h09, 1'b0, 16'h0909);
        tick;
        outs("c.miss", 1'b1, 8'h09, 1'b0);
        drive(1'b1, 8'h02, 8'h09, 1'b1, 16'h0909);
        tick;
        outs("c.missdone", 1'b0, 8'h09, 1'b1);
        result("c.missdone", 16'h0909, 8'h02);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 16'h0000);
        tick;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/warp_fetcher.md
WARP_FETCHER -- requirements
Module: warp_fetcher

Interface
REQ-001 Parameters SHALL be: PROGRAM_MEM_ADDR_BITS, default 8, PC/address width; PROGRAM_MEM_DATA_BITS, default 16, instruction width; MAX_WARPS_PER_CORE, default 4, warp slots.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fetch_req  input  1  scheduler requests the instruction for warp_id at pc; held high until the instruction is taken.
REQ-005 warp_id  input  8  warp being fetched.
REQ-006 pc  input  PROGRAM_MEM_ADDR_BITS  program counter of that warp.
REQ-007 mem_read_valid  output  1  read request to program memory.
REQ-008 mem_read_address  output  PROGRAM_MEM_ADDR_BITS  read address.
REQ-009 mem_read_ready  input  1  memory accepts the request and returns data in the same cycle.
REQ-010 mem_read_data  input  PROGRAM_MEM_DATA_BITS  instruction word, valid while mem_read_ready is high.
REQ-011 instruction_ready  output  1  instruction output is valid for fetch_warp_id.
REQ-012 instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction.
REQ-013 fetch_warp_id  output  8  warp the held instruction belongs to.

Function
REQ-014 The FSM SHALL have three states: IDLE, FETCHING, FETCHED.
REQ-015 IDLE: on fetch_req=1, latch warp_id/pc into internal registers, drive mem_read_address=pc, move to FETCHING; mem_read_valid SHALL be high from the next cycle.
REQ-016 FETCHING: mem_read_valid SHALL stay high with a stable address until the cycle mem_read_ready=1 is sampled.
REQ-017 In that cycle, mem_read_data SHALL be captured into instruction, mem_read_valid SHALL drop on the next edge, and the FSM SHALL move to FETCHED.
REQ-018 FETCHED: instruction_ready SHALL be 1; instruction and fetch_warp_id SHALL be stable.
REQ-019 FETCHED: fetch_req=0 SHALL return the FSM to IDLE, clearing instruction_ready on the next edge.
REQ-020 FETCHED: fetch_req=1 with warp_id or pc differing from the latched values SHALL be treated as a new request: instruction_ready drops and the FSM re-enters FETCHING for the new address.
REQ-021 fetch_req deasserting during FETCHING SHALL NOT abort the memory transaction; the completed data SHALL be discarded and the FSM SHALL go to IDLE with instruction_ready low.
REQ-022 Minimum latency SHALL be: fetch_req seen at cycle N, mem_read_valid at N+1, ready at N+1, instruction_ready at N+2.
REQ-023 warp_id and pc SHALL be ignored outside IDLE and FETCHED.
REQ-024 An address with all PC bits set (0xFF at default width) SHALL be fetched normally; no wrap logic is applied.

Reset
REQ-025 Reset SHALL force IDLE, mem_read_valid=0, mem_read_address=0, instruction_ready=0, instruction=0, fetch_warp_id=0, and invalidate all cache entries.
REQ-026 Reset during FETCHING SHALL drop mem_read_valid on the reset edge; any data returned afterwards SHALL be ignored.

Configuration
REQ-027 Macro FETCH_CACHE_EN: when defined, the block SHALL hold one entry per warp slot: valid bit, PC tag and instruction.
REQ-028 With FETCH_CACHE_EN, a request in IDLE whose warp_id < MAX_WARPS_PER_CORE and whose pc matches a valid tag SHALL go directly to FETCHED on the next edge with the cached instruction and no memory request.
REQ-029 With FETCH_CACHE_EN, every completed memory fetch for an in-range warp SHALL write that warp's entry. Out-of-range warp_id SHALL bypass the cache.
REQ-030 Without FETCH_CACHE_EN, every request SHALL go to memory, and no cache storage SHALL be synthesized.

Verification
REQ-031 Reset, then fetch_req=1, warp_id=0, pc=0x00, mem_read_ready=1 immediately -> mem_read_valid high 1 cycle at address 0x00; instruction_ready at N+2 with instruction=data and fetch_warp_id=0.
REQ-032 pc=0x10, mem_read_ready delayed 3 cycles -> mem_read_valid held 3 cycles at 0x10; instruction_ready one cycle after ready; drops one cycle after fetch_req=0.
REQ-033 In FETCHED, warp_id changes 0->1 and pc changes to 0x04 with fetch_req held -> instruction_ready low next cycle; new read at 0x04; fetch_warp_id=1 on completion.
REQ-034 fetch_req dropped mid-FETCHING -> transaction completes, instruction_ready never asserts, FSM returns to IDLE.
REQ-035 Reset asserted while mem_read_valid=1 -> mem_read_valid=0 and all outputs zero after the reset edge; a late mem_read_ready is ignored.
REQ-036 FETCH_CACHE_EN: warp 2 fetches pc=0x08, then re-requests pc=0x08 -> instruction_ready next cycle, mem_read_valid stays 0; pc=0x09 -> memory read.
